fp_divider: RTL and testbench

- Multi-cycle single-precision floating-point divider, z = x / y.
- Sibling execution stage to the FP multiplier in the core's FP datapath, fed from the same register-read operands.
- Result is consumed by the same writeback mux.
- Uses the same run/stall handshake as the multiplier, so the core's stall logic ORs it in unchanged.
- Restoring radix-2 division: one quotient bit per cycle, result rounded half-up.

---
 rtl/fp_divider.sv | 63 ++++++
 tb/tb_fp_divider.sv | 105 ++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// fp_divider: multi-cycle single-precision divider, restoring radix-2, one quotient bit per cycle.
// Shares the run/stall handshake with the FP multiplier; z is valid when run=1 and stall=0.
module fp_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        stall,
    output logic [31:0] z
);
    logic [4:0]        r_s;
    logic [24:0]       r_r;
    logic [25:0]       r_q;
    logic [23:0]       w_ym;
    logic              w_d;
    logic [24:0]       w_rd;
    logic [25:0]       w_m;
    logic              w_c;
    logic [22:0]       w_frac;
    logic signed [9:0] w_e;
    logic              w_sign;

    assign w_ym = {1'b1, y[22:0]};
    assign w_d  = r_r >= {1'b0, w_ym};
    assign w_rd = w_d ? r_r - {1'b0, w_ym} : r_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= 5'd0;
            r_r <= 25'd0;
            r_q <= 26'd0;
        end else if (!run) begin
            r_s <= 5'd0;
        end else if (r_s == 5'd0) begin
            r_r <= {2'b01, x[22:0]};
            r_q <= 26'd0;
            r_s <= 5'd1;
        end else if (r_s != 5'd27) begin
            r_r <= {w_rd[23:0], 1'b0};
            r_q <= {r_q[24:0], w_d};
            r_s <= r_s + 5'd1;
        end
    end

    assign stall = run & (r_s != 5'd27);

    // Q[25] is the integer bit; the +1 at the LSB rounds half-up.
    assign w_m    = r_q[25] ? {1'b0, r_q[25:1]} + 26'd1 : {1'b0, r_q[24:0]} + 26'd1;
    assign w_c    = w_m[25];
    assign w_frac = w_c ? 23'd0 : w_m[23:1];
    assign w_sign = x[31] ^ y[31];
    assign w_e    = {2'b00, x[30:23]} - {2'b00, y[30:23]} + 10'sd126
                  + {9'd0, r_q[25]} + {9'd0, w_c};

    always_comb begin
        z = {w_sign, w_e[7:0], w_frac};
        z = (w_e >= 10'sd255)      ? {w_sign, 8'hFF, 23'd0} : z;
        z = (w_e <= 10'sd0)        ? 32'd0                  : z;
        z = (y[30:23] == 8'd0)     ? {w_sign, 8'hFF, 23'd0} : z;
        z = (x[30:23] == 8'd0)     ? 32'd0                  : z;
    end
endmodule

// File: tb/tb_fp_divider.sv
// tb_fp_divider: directed vectors; stimulus pushes expected quotients, a monitor pops on each result.
module tb_fp_divider;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        stall;
    logic [31:0] z;
    logic [31:0] exp_q[$];
    logic        got = 1'b0;
    int          checks = 0;
    int          errors = 0;

    fp_divider dut (.clk(clk), .rst(rst), .run(run), .x(x), .y(y), .stall(stall), .z(z));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!run || rst) got = 1'b0;
        else if (!stall && !got) begin
            got = 1'b1;
            if (exp_q.size() == 0) check("unexpected_result", z, 32'hxxxxxxxx);
            else check("quotient", z, exp_q.pop_front());
        end
    end

    // Counts stall-high negedges from the current cycle until stall falls.
    task automatic count_stall(output int cnt);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            cnt++;
            if (cnt > 100) break;
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e, input int hold);
        int cnt;
        @(posedge clk); #1;
        x = a; y = b; run = 1'b1;
        exp_q.push_back(e);
        count_stall(cnt);
        check("stall_cycles", cnt, 27);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stall", {31'd0, stall}, 32'd0);
            check("hold_z", z, e);
        end
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    initial begin
        int cnt;
        #12 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        run_div(32'h40C00000, 32'h40000000, 32'h40400000, 0);
        run_div(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 0);
        run_div(32'hBF800000, 32'h40800000, 32'hBE800000, 0);
        run_div(32'h00000000, 32'h40000000, 32'h00000000, 0);
        run_div(32'h3F800000, 32'h00000000, 32'h7F800000, 0);
        run_div(32'h7F000000, 32'h00800000, 32'h7F800000, 0);
        run_div(32'h00800000, 32'h7F000000, 32'h00000000, 0);
        run_div(32'h40C00000, 32'h40000000, 32'h40400000, 40);
        // Abandon a divide at S=10, then restart.
        @(posedge clk); #1;
        x = 32'h3F800000; y = 32'h40400000; run = 1'b1;
        repeat (10) @(posedge clk);
        #1 run = 1'b0;
        run_div(32'h40C00000, 32'h40000000, 32'h40400000, 0);
        // Reset mid-divide.
        @(posedge clk); #1;
        x = 32'h3F800000; y = 32'h40400000; run = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(32'h3EAAAAAB);
        count_stall(cnt);
        check("rst_mid_restart_cycles", cnt, 27);
        // Reset after completion must raise stall without a clock edge.
        @(posedge clk); #2 rst = 1'b1;
        #1 check("rst_done_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        exp_q.push_back(32'h3EAAAAAB);
        count_stall(cnt);
        check("rst_done_restart_cycles", cnt, 27);
        @(posedge clk); #1 run = 1'b0;
        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
